// File: rtl/spu_issue_pkg.sv
`default_nettype none
// ============================================================================
// spu_issue_pkg
// ----------------------------------------------------------------------------
// Shared types and helpers for the SPU dual-issue stage: register address and
// latency widths, the decoded slot record, and the source-match helper used
// by the hazard logic.
// Revision: 1.0 - initial release
// ============================================================================
package spu_issue_pkg;

  localparam int NUM_REGS    = 128;
  localparam int LAT_W       = 3;
  localparam int REG_ADDR_W  = 7;
  // Each slot looks up ra, rb, rc and rt; two slots per pair.
  localparam int NUM_LOOKUPS = 8;

  // Lookup port offsets within one slot's group of four.
  localparam int LK_RA = 0;
  localparam int LK_RB = 1;
  localparam int LK_RC = 2;
  localparam int LK_RT = 3;

  typedef logic [LAT_W-1:0]      lat_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    logic      valid;
    logic      reg_write;
    reg_addr_t rt_addr;
    reg_addr_t ra_addr;
    reg_addr_t rb_addr;
    reg_addr_t rc_addr;
    logic [2:0] src_use;   // bit0 = ra, bit1 = rb, bit2 = rc
    lat_t      latency;
  } slot_t;

  // True when any source the slot actually reads equals the given register.
  function automatic logic src_match(input slot_t s, input reg_addr_t rt);
    return (s.src_use[0] && (s.ra_addr == rt)) ||
           (s.src_use[1] && (s.rb_addr == rt)) ||
           (s.src_use[2] && (s.rc_addr == rt));
  endfunction

endpackage
`default_nettype wire

// File: rtl/spu_issue_stage_scoreboard.sv
`default_nettype none
// ============================================================================
// issue_scoreboard
// ----------------------------------------------------------------------------
// Per-register countdown scoreboard. A nonzero counter means a write to that
// register is still in flight; it reaches zero when the value is readable.
// Ports:
//   clock, reset          - clock, asynchronous active-high reset
//   set_even_* / set_odd_* - load request (enable, register, latency)
//   rd_addr / rd_cnt      - combinational counter lookups
// Revision: 1.0 - initial release
// ============================================================================
module issue_scoreboard
  import spu_issue_pkg::*;
#(
  parameter int NUM_RD = NUM_LOOKUPS
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      set_even_en,
  input  reg_addr_t set_even_addr,
  input  lat_t      set_even_lat,
  input  logic      set_odd_en,
  input  reg_addr_t set_odd_addr,
  input  lat_t      set_odd_lat,
  input  reg_addr_t rd_addr [NUM_RD],
  output lat_t      rd_cnt  [NUM_RD]
);

  lat_t cnt [NUM_REGS];

  // The odd slot is younger, so when both write the same register its
  // latency is the one that must be honoured.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (set_odd_en && (set_odd_addr == reg_addr_t'(r)))
          cnt[r] <= set_odd_lat;
        else if (set_even_en && (set_even_addr == reg_addr_t'(r)))
          cnt[r] <= set_even_lat;
        else if (cnt[r] != '0)
          cnt[r] <= cnt[r] - lat_t'(1);
      end
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    assign rd_cnt[i] = cnt[rd_addr[i]];
  end

endmodule
`default_nettype wire

// File: rtl/spu_issue_stage.sv
`default_nettype none
// ============================================================================
// spu_issue_stage
// ----------------------------------------------------------------------------
// Dual-issue in-order issue stage. Buffers one even/odd pair, checks each
// pending slot against the scoreboard and against its older pair mate, and
// presents issuing instructions on registered outputs.
// Ports:
//   clock, reset, flush            - clock, async reset, synchronous flush
//   in_valid / in_ready            - pair handshake from the decoder
//   even_/odd_instr, even_/odd_slot - incoming pair
//   issue_even_* / issue_odd_*     - registered issue to the register file
//   stall_count                    - saturating stall-cycle counter
// Revision: 1.0 - initial release
// ============================================================================
module spu_issue_stage
  import spu_issue_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] even_instr,
  input  logic [31:0] odd_instr,
  input  slot_t       even_slot,
  input  slot_t       odd_slot,
  output logic        issue_even_valid,
  output logic        issue_odd_valid,
  output logic [31:0] issue_even_instr,
  output logic [31:0] issue_odd_instr,
  output slot_t       issue_even_slot,
  output slot_t       issue_odd_slot,
  output logic [15:0] stall_count
);

  logic        even_pend, odd_pend;
  logic [31:0] buf_even_instr, buf_odd_instr;
  slot_t       buf_even, buf_odd;

  reg_addr_t   rd_addr [NUM_LOOKUPS];
  lat_t        rd_cnt  [NUM_LOOKUPS];

  logic even_haz, odd_sb_haz, intra_haz;
  logic even_go, odd_go, accept, stall;

  // Scoreboard-only hazard: a used source still in flight, or a write whose
  // latency would complete before an older pending write to the same rt.
  function automatic logic sb_hazard(input slot_t s, input lat_t ca,
                                     input lat_t cb, input lat_t cc,
                                     input lat_t crt);
    return (s.src_use[0] && (ca != '0)) ||
           (s.src_use[1] && (cb != '0)) ||
           (s.src_use[2] && (cc != '0)) ||
           (s.reg_write && (crt > s.latency));
  endfunction

  assign rd_addr[LK_RA]     = buf_even.ra_addr;
  assign rd_addr[LK_RB]     = buf_even.rb_addr;
  assign rd_addr[LK_RC]     = buf_even.rc_addr;
  assign rd_addr[LK_RT]     = buf_even.rt_addr;
  assign rd_addr[4 + LK_RA] = buf_odd.ra_addr;
  assign rd_addr[4 + LK_RB] = buf_odd.rb_addr;
  assign rd_addr[4 + LK_RC] = buf_odd.rc_addr;
  assign rd_addr[4 + LK_RT] = buf_odd.rt_addr;

  assign even_haz   = sb_hazard(buf_even, rd_cnt[LK_RA], rd_cnt[LK_RB],
                                rd_cnt[LK_RC], rd_cnt[LK_RT]);
  assign odd_sb_haz = sb_hazard(buf_odd, rd_cnt[4 + LK_RA], rd_cnt[4 + LK_RB],
                                rd_cnt[4 + LK_RC], rd_cnt[4 + LK_RT]);

  // Same-cycle dependence on the even slot; the scoreboard does not yet
  // reflect the even write, so these cases are caught here.
  assign intra_haz = (buf_even.reg_write && src_match(buf_odd, buf_even.rt_addr)) ||
                     (buf_even.reg_write && buf_odd.reg_write &&
                      (buf_even.rt_addr == buf_odd.rt_addr) &&
                      (buf_even.latency > buf_odd.latency));

  assign even_go = even_pend && !flush && !even_haz;
  // In-order: odd goes with the even slot or after it has left.
  assign odd_go  = odd_pend && !flush && !odd_sb_haz &&
                   (even_go ? !intra_haz : !even_pend);

  assign in_ready = !flush && (!even_pend || even_go) && (!odd_pend || odd_go);
  assign accept   = in_valid && in_ready;
  assign stall    = (even_pend && !even_go) || (odd_pend && !odd_go);

  issue_scoreboard #(.NUM_RD(NUM_LOOKUPS)) u_scoreboard (
    .clock         (clock),
    .reset         (reset),
    .set_even_en   (even_go && buf_even.reg_write),
    .set_even_addr (buf_even.rt_addr),
    .set_even_lat  (buf_even.latency),
    .set_odd_en    (odd_go && buf_odd.reg_write),
    .set_odd_addr  (buf_odd.rt_addr),
    .set_odd_lat   (buf_odd.latency),
    .rd_addr       (rd_addr),
    .rd_cnt        (rd_cnt)
  );

  // Pair buffer
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      even_pend      <= 1'b0;
      odd_pend       <= 1'b0;
      buf_even_instr <= '0;
      buf_odd_instr  <= '0;
      buf_even       <= '0;
      buf_odd        <= '0;
    end else if (flush) begin
      even_pend <= 1'b0;
      odd_pend  <= 1'b0;
    end else if (accept) begin
      even_pend      <= even_slot.valid;
      odd_pend       <= odd_slot.valid;
      buf_even_instr <= even_instr;
      buf_odd_instr  <= odd_instr;
      buf_even       <= even_slot;
      buf_odd        <= odd_slot;
    end else begin
      even_pend <= even_pend && !even_go;
      odd_pend  <= odd_pend && !odd_go;
    end
  end

  // Issue registers: valid pulses for one cycle per issued instruction.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      issue_even_valid <= 1'b0;
      issue_odd_valid  <= 1'b0;
      issue_even_instr <= '0;
      issue_odd_instr  <= '0;
      issue_even_slot  <= '0;
      issue_odd_slot   <= '0;
    end else begin
      issue_even_valid <= even_go;
      issue_odd_valid  <= odd_go;
      if (even_go) begin
        issue_even_instr <= buf_even_instr;
        issue_even_slot  <= buf_even;
      end
      if (odd_go) begin
        issue_odd_instr <= buf_odd_instr;
        issue_odd_slot  <= buf_odd;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      stall_count <= '0;
    else if (stall && (stall_count != 16'hFFFF))
      stall_count <= stall_count + 16'd1;
  end

endmodule
`default_nettype wire

// File: tb/tb_spu_issue_stage.sv
`default_nettype none
// ============================================================================
// tb_spu_issue_stage
// ----------------------------------------------------------------------------
// Scoreboard bench for spu_issue_stage. Each offered pair is run through a
// timestamp model: every register carries the first edge at which a reader
// may issue, and each slot's issue edge is the earliest edge meeting its
// constraints. Predicted issues are queued; a monitor pops and compares.
// Revision: 1.0 - initial release
// ============================================================================
module tb_spu_issue_stage;
  import spu_issue_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] even_instr = '0, odd_instr = '0;
  slot_t       even_slot = '0, odd_slot = '0;
  logic        issue_even_valid, issue_odd_valid;
  logic [31:0] issue_even_instr, issue_odd_instr;
  slot_t       issue_even_slot, issue_odd_slot;
  logic [15:0] stall_count;

  spu_issue_stage dut (
    .clock            (clock),
    .reset            (reset),
    .flush            (flush),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .even_instr       (even_instr),
    .odd_instr        (odd_instr),
    .even_slot        (even_slot),
    .odd_slot         (odd_slot),
    .issue_even_valid (issue_even_valid),
    .issue_odd_valid  (issue_odd_valid),
    .issue_even_instr (issue_even_instr),
    .issue_odd_instr  (issue_odd_instr),
    .issue_even_slot  (issue_even_slot),
    .issue_odd_slot   (issue_odd_slot),
    .stall_count      (stall_count)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc = cyc + 1;

  typedef struct {
    int          at_edge;
    bit          is_odd;
    logic [31:0] instr;
    slot_t       slot;
  } exp_t;

  exp_t expq[$];
  int   rdy [NUM_REGS];   // first edge at which a reader of r may issue
  int   last_issue = 0;
  int   last_accept = 0;
  int   stall_exp = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int earliest(input slot_t s, input int lo);
    int j = lo;
    if (s.src_use[0]) j = imax(j, rdy[s.ra_addr]);
    if (s.src_use[1]) j = imax(j, rdy[s.rb_addr]);
    if (s.src_use[2]) j = imax(j, rdy[s.rc_addr]);
    // A write may land once the older write has at most its own latency left.
    if (s.reg_write) j = imax(j, rdy[s.rt_addr] - int'(s.latency));
    return j;
  endfunction

  function automatic slot_t mk(input bit v, input bit w, input int rt, input int ra,
                               input int rb, input int rc, input bit [2:0] use_, input int lat);
    slot_t s;
    s.valid = v; s.reg_write = w;
    s.rt_addr = reg_addr_t'(rt); s.ra_addr = reg_addr_t'(ra);
    s.rb_addr = reg_addr_t'(rb); s.rc_addr = reg_addr_t'(rc);
    s.src_use = use_; s.latency = lat_t'(lat);
    return s;
  endfunction

  function automatic int rand_reg();
    return ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, NUM_REGS - 1))
                                       : int'($urandom_range(0, 7));
  endfunction

  function automatic slot_t rand_slot();
    return mk($urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1, rand_reg(), rand_reg(),
              rand_reg(), rand_reg(), 3'($urandom_range(0, 7)), int'($urandom_range(1, 7)));
  endfunction

  // Predict issue edges for a pair accepted at edge a and update the model.
  task automatic model_pair(input int a, input logic [31:0] ie, input slot_t se,
                            input logic [31:0] io, input slot_t so);
    int e = -1, o = -1, c, last;
    bit intra, even_applied = 0;
    exp_t x;
    if (se.valid) e = earliest(se, a + 1);
    if (so.valid) begin
      if (se.valid) begin
        c = earliest(so, e);
        intra = (se.reg_write && src_match(so, se.rt_addr)) ||
                (se.reg_write && so.reg_write && se.rt_addr == so.rt_addr &&
                 se.latency > so.latency);
        if (c == e && !intra) o = e;
        else begin
          if (se.reg_write) rdy[se.rt_addr] = e + int'(se.latency) + 1;
          even_applied = 1;
          o = earliest(so, e + 1);
        end
      end else begin
        o = earliest(so, a + 1);
      end
    end
    if (se.valid && se.reg_write && !even_applied) rdy[se.rt_addr] = e + int'(se.latency) + 1;
    if (so.valid && so.reg_write) rdy[so.rt_addr] = o + int'(so.latency) + 1;
    if (se.valid) begin
      x.at_edge = e; x.is_odd = 0; x.instr = ie; x.slot = se; expq.push_back(x);
    end
    if (so.valid) begin
      x.at_edge = o; x.is_odd = 1; x.instr = io; x.slot = so; expq.push_back(x);
    end
    last = imax(a, imax(e, o));
    if (se.valid || so.valid) stall_exp += last - a - 1;
    last_issue  = last;
    last_accept = a;
  endtask

  // Called at a negedge; returns at the negedge after the acceptance edge.
  task automatic offer(input logic [31:0] ie, input slot_t se, input logic [31:0] io, input slot_t so);
    int a_exp, n = 0;
    in_valid = 1'b1; even_instr = ie; even_slot = se; odd_instr = io; odd_slot = so;
    a_exp = imax(cyc + 1, last_issue);
    model_pair(a_exp, ie, se, io, so);
    #1;
    while (!in_ready && n < 300) begin
      @(negedge clock); #1; n++;
    end
    chk("accept_edge", 64'(cyc + 1), 64'(a_exp));
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic model_reset();
    expq.delete();
    for (int r = 0; r < NUM_REGS; r++) rdy[r] = 0;
    last_issue = 0;
    stall_exp = 0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (expq.size() != 0 && n < 200) begin
      @(negedge clock); n++;
    end
    chk("drain_empty", 64'(expq.size()), 64'd0);
    @(negedge clock);
    #1;
  endtask

  task automatic check_out(input bit is_odd, input logic [31:0] instr, input slot_t slot);
    exp_t x;
    if (expq.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_issue: odd=%0d instr %0h at edge %0d, none required", is_odd, instr, cyc);
    end else begin
      x = expq.pop_front();
      chk("issue_edge", 64'(cyc), 64'(x.at_edge));
      chk("issue_slot_sel", 64'(is_odd), 64'(x.is_odd));
      chk("issue_instr", 64'(instr), 64'(x.instr));
      chk("issue_slot", 64'(slot), 64'(x.slot));
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      while (expq.size() != 0 && expq[0].at_edge < cyc) begin
        checks++; errors++;
        $display("FAIL missed_issue: got nothing at edge %0d, required odd=%0d instr %0h",
                 expq[0].at_edge, expq[0].is_odd, expq[0].instr);
        void'(expq.pop_front());
      end
      if (issue_even_valid) check_out(1'b0, issue_even_instr, issue_even_slot);
      if (issue_odd_valid)  check_out(1'b1, issue_odd_instr, issue_odd_slot);
    end
  end

  initial begin
    int f_edge;
    model_reset();
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_even_valid", 64'(issue_even_valid), 64'd0);
    chk("rst_odd_valid", 64'(issue_odd_valid), 64'd0);
    chk("rst_even_instr", 64'(issue_even_instr), 64'd0);
    chk("rst_odd_instr", 64'(issue_odd_instr), 64'd0);
    chk("rst_even_slot", 64'(issue_even_slot), 64'd0);
    chk("rst_odd_slot", 64'(issue_odd_slot), 64'd0);
    chk("rst_stall", 64'(stall_count), 64'd0);

    // Independent pair
    @(negedge clock);
    offer(32'hA0000001, mk(1, 1, 5, 0, 0, 0, 3'b000, 2),
          32'hA0000002, mk(1, 1, 7, 1, 2, 3, 3'b111, 4));
    drain();

    // RAW across pairs: reader waits three stall cycles
    do_reset();
    offer(32'hB0000001, mk(1, 1, 5, 0, 0, 0, 3'b000, 3), 32'h0, mk(0, 0, 0, 0, 0, 0, 3'b000, 1));
    offer(32'hB0000002, mk(1, 0, 1, 5, 0, 0, 3'b001, 1), 32'h0, mk(0, 0, 0, 0, 0, 0, 3'b000, 1));
    drain();
    chk("raw_stall_count", 64'(stall_count), 64'd3);

    // Intra-pair split
    do_reset();
    offer(32'hC0000001, mk(1, 1, 9, 0, 0, 0, 3'b000, 2),
          32'hC0000002, mk(1, 0, 2, 0, 9, 0, 3'b010, 1));
    drain();
    chk("split_stall_count", 64'(stall_count), 64'd3);

    // WAW inside a pair, both latency orders
    offer(32'hD0000001, mk(1, 1, 12, 0, 0, 0, 3'b000, 6),
          32'hD0000002, mk(1, 1, 12, 0, 0, 0, 3'b000, 2));
    offer(32'hD0000003, mk(1, 1, 12, 0, 0, 0, 3'b000, 2),
          32'hD0000004, mk(1, 1, 12, 0, 0, 0, 3'b000, 6));
    offer(32'hD0000005, mk(1, 0, 0, 12, 0, 0, 3'b001, 1), 32'h0, mk(0, 0, 0, 0, 0, 0, 3'b000, 1));
    drain();
    chk("waw_stall_count", 64'(stall_count), 64'(stall_exp));

    // Flush while the odd slot is held; r9 keeps counting down
    do_reset();
    offer(32'hE0000001, mk(1, 1, 9, 0, 0, 0, 3'b000, 4),
          32'hE0000002, mk(1, 0, 3, 9, 0, 0, 3'b001, 1));
    @(negedge clock);
    flush = 1'b1;
    f_edge = cyc + 1;
    #1;
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    @(negedge clock);
    flush = 1'b0;
    chk("flush_even_valid", 64'(issue_even_valid), 64'd0);
    chk("flush_odd_valid", 64'(issue_odd_valid), 64'd0);
    while (expq.size() != 0 && expq[$].at_edge >= f_edge) void'(expq.pop_back());
    stall_exp  = stall_exp - (last_issue - last_accept - 1) + (f_edge - last_accept);
    last_issue = f_edge;
    offer(32'hE0000003, mk(1, 0, 4, 9, 0, 0, 3'b001, 1), 32'h0, mk(0, 0, 0, 0, 0, 0, 3'b000, 1));
    drain();
    chk("flush_stall_count", 64'(stall_count), 64'(stall_exp));

    // Asynchronous reset while r5 is counting down
    do_reset();
    offer(32'hF0000001, mk(1, 1, 5, 0, 0, 0, 3'b000, 2), 32'h0, mk(0, 0, 0, 0, 0, 0, 3'b000, 1));
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_even_valid", 64'(issue_even_valid), 64'd0);
    chk("arst_even_instr", 64'(issue_even_instr), 64'd0);
    chk("arst_even_slot", 64'(issue_even_slot), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    offer(32'hF0000002, mk(1, 0, 6, 0, 0, 5, 3'b100, 1), 32'h0, mk(0, 0, 0, 0, 0, 0, 3'b000, 1));
    drain();
    chk("arst_stall_count", 64'(stall_count), 64'd0);

    // Randomized traffic
    do_reset();
    for (int p = 0; p < 300; p++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clock);
      offer($urandom, rand_slot(), $urandom, rand_slot());
    end
    drain();
    chk("rand_stall_count", 64'(stall_count), 64'(stall_exp));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
